master_req_queue: RTL and testbench

- Request buffer that sits directly upstream of one crossbar master port.
- Accepts read/write requests from a core through a valid/ready push interface and queues them in order.
- Issues each request on the crossbar master req/cmd/addr/wdata lines and holds it until ack.
- Counts outstanding reads and returns read data to the core when resp arrives.

---
 rtl/master_req_queue.sv | 89 ++++++++
 tb/tb_master_req_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/master_req_queue.sv
// In-order request buffer in front of one crossbar master port.
// Holds each request on the master lines until ack, throttles reads at MAX_RD outstanding and returns read data.
module master_req_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_rvalid,
  output logic [DATA_W-1:0] out_rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic              err,
  output logic              master_req,
  output logic              master_cmd,
  output logic [ADDR_W-1:0] master_addr,
  output logic [DATA_W-1:0] master_wdata,
  input  logic              master_ack,
  input  logic [DATA_W-1:0] master_rdata,
  input  logic              master_resp
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_RD) + 1;

  logic              mem_cmd  [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_wdata[DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rd_cnt;
  logic          full, empty, push, pop, rd_inc, rd_dec;
  logic [AW-1:0] head_idx;

  // Extra pointer MSB tells a full ring from an empty one after wrap.
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign level    = wr_ptr - rd_ptr;

  assign head_idx     = rd_ptr[AW-1:0];
  assign master_cmd   = mem_cmd[head_idx];
  assign master_addr  = mem_addr[head_idx];
  assign master_wdata = mem_wdata[head_idx];
  // Reads stall at the head once MAX_RD are unanswered; writes always go.
  assign master_req   = !empty && (master_cmd || (rd_cnt < CW'(MAX_RD)));
  assign pop          = master_req && master_ack;

  assign rd_inc = pop && !master_cmd;
  assign rd_dec = master_resp && (rd_cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr[AW-1:0]]   <= in_cmd;
      mem_addr[wr_ptr[AW-1:0]]  <= in_addr;
      mem_wdata[wr_ptr[AW-1:0]] <= in_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      err        <= 1'b0;
      out_rvalid <= 1'b0;
      out_rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + CW'(1);
        2'b01:   rd_cnt <= rd_cnt - CW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
      out_rvalid <= rd_dec;
      if (master_resp) out_rdata <= master_rdata;
      // A response with nothing outstanding is dropped but remembered.
      if (master_resp && (rd_cnt == '0)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_master_req_queue.sv
// Randomized + directed bench for master_req_queue against a queue-based reference model.
module tb_master_req_queue;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int MAX_RD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic out_rvalid;
  logic [DATA_W-1:0] out_rdata;
  logic [$clog2(DEPTH):0] level;
  logic err, master_req, master_cmd, master_ack, master_resp;
  logic [ADDR_W-1:0] master_addr;
  logic [DATA_W-1:0] master_wdata, master_rdata;

  master_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_RD(MAX_RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_rvalid(out_rvalid), .out_rdata(out_rdata),
    .level(level), .err(err),
    .master_req(master_req), .master_cmd(master_cmd),
    .master_addr(master_addr), .master_wdata(master_wdata),
    .master_ack(master_ack), .master_rdata(master_rdata), .master_resp(master_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        cmd;
    bit [31:0] addr;
    bit [31:0] wdata;
  } ent_t;

  ent_t      q[$];
  int        rd_cnt;
  bit        m_err, m_rv;
  bit [31:0] m_rd;
  int        tests, fails;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return (q.size() > 0) && (q[0].cmd || rd_cnt < MAX_RD);
  endfunction

  task automatic compare();
    chk("level", 64'(level), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("master_req", 64'(master_req), 64'(model_req()));
    chk("err", 64'(err), 64'(m_err));
    chk("out_rvalid", 64'(out_rvalid), 64'(m_rv));
    chk("out_rdata", 64'(out_rdata), 64'(m_rd));
    if (model_req()) begin
      chk("master_cmd", 64'(master_cmd), 64'(q[0].cmd));
      chk("master_addr", 64'(master_addr), 64'(q[0].addr));
      chk("master_wdata", 64'(master_wdata), 64'(q[0].wdata));
    end
  endtask

  // Advance the model by one edge using the inputs currently driven, then check at the falling edge.
  task automatic cycle();
    bit pop, push, dec;
    ent_t e;
    if (!rst_n) begin
      q.delete(); rd_cnt = 0; m_err = 0; m_rv = 0; m_rd = '0;
    end else begin
      pop  = model_req() && master_ack;
      push = in_valid && (q.size() < DEPTH);
      dec  = master_resp && rd_cnt > 0;
      m_rv = dec;
      if (master_resp) m_rd = master_rdata;
      if (master_resp && rd_cnt == 0) m_err = 1;
      if (pop && !q[0].cmd) rd_cnt++;
      if (dec) rd_cnt--;
      if (pop) q.delete(0);
      if (push) begin
        e.cmd = in_cmd; e.addr = in_addr; e.wdata = in_wdata;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit v, input bit c, input logic [31:0] a, input logic [31:0] w,
                       input bit ack, input bit resp, input logic [31:0] rd);
    in_valid = v; in_cmd = c; in_addr = a; in_wdata = w;
    master_ack = ack; master_resp = resp; master_rdata = rd;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("rst_level", 64'(level), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_req", 64'(master_req), 0);
    rst_n = 1'b1;

    // Write burst with ack held high
    drive(1, 1, 1, 1, 1, 0, 0); cycle();
    chk("wb_req1", 64'(master_req), 1); chk("wb_addr1", 64'(master_addr), 1);
    drive(1, 1, 2, 2, 1, 0, 0); cycle();
    chk("wb_req2", 64'(master_req), 1); chk("wb_addr2", 64'(master_addr), 2);
    drive(1, 1, 3, 3, 1, 0, 0); cycle();
    chk("wb_req3", 64'(master_req), 1); chk("wb_addr3", 64'(master_addr), 3);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    chk("wb_level0", 64'(level), 0); chk("wb_req_low", 64'(master_req), 0);
    chk("wb_no_rvalid", 64'(out_rvalid), 0);

    // Read held through two wait cycles, response three cycles after the ack
    drive(1, 0, 32'h8000_0001, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    chk("rd_wait_req", 64'(master_req), 1);
    chk("rd_wait_addr", 64'(master_addr), 64'h8000_0001);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    drive(0, 0, 0, 0, 0, 1, 32'h07); cycle();
    chk("rd_rvalid", 64'(out_rvalid), 1); chk("rd_rdata", 64'(out_rdata), 7);
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    chk("rd_rvalid_pulse", 64'(out_rvalid), 0);

    // Fill the FIFO, try a fifth push, then free one slot
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h10 + i, i, 0, 0, 0); cycle();
    end
    chk("full_level", 64'(level), 4); chk("full_ready", 64'(in_ready), 0);
    drive(1, 1, 32'h99, 0, 0, 0, 0); cycle();
    chk("full_ignored", 64'(level), 4);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    chk("full_pop_level", 64'(level), 3); chk("full_pop_ready", 64'(in_ready), 1);
    cycle(); cycle(); cycle();
    chk("full_drained", 64'(level), 0);

    // Five reads, no responses: the fifth is throttled
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h20 + i, 0, 1, 0, 0); cycle();
    end
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    chk("thr_req_low", 64'(master_req), 0); chk("thr_level", 64'(level), 1);
    drive(0, 0, 0, 0, 0, 1, 32'hA1); cycle();
    chk("thr_req_back", 64'(master_req), 1); chk("thr_addr", 64'(master_addr), 64'h24);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    chk("thr_issued", 64'(level), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'hB0 + i); cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // Stray response, then reset with two entries queued
    drive(0, 0, 0, 0, 0, 1, 32'h55); cycle();
    chk("stray_err", 64'(err), 1); chk("stray_rvalid", 64'(out_rvalid), 0);
    drive(1, 1, 1, 1, 0, 0, 0); cycle(); cycle();
    chk("pre_rst_level", 64'(level), 2);
    drive(0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("rst2_level", 64'(level), 0); chk("rst2_req", 64'(master_req), 0);
    chk("rst2_err", 64'(err), 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, $urandom,
            $urandom_range(0, 9) < 6,
            (rd_cnt > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 2),
            $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
